painterengine_gpu_dvi_scanout: RTL

Framebuffer scanout controller sitting between the GPU memory read port and the DVI timing generator. Per frame it sequences burst reads of the active framebuffer (clip_width x clip_height 32-bit pixels) into an internal pixel FIFO and supplies one pixel per next_rgb strobe. It also owns double-buffer swap, applied only at frame boundaries, and reports FIFO underflow.

---
 rtl/painterengine_gpu_dvi_scanout_if.sv | 23 ++
 rtl/painterengine_gpu_dvi_scanout.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/painterengine_gpu_dvi_scanout_if.sv
// Burst read port between the scanout controller and the GPU memory.
// Request channel is valid/ready; data beats are valid-only and cannot be stalled.
// Master drives requests, slave returns data beats.
interface painterengine_gpu_dvi_scanout_if #(
  parameter int ADDRESS_WIDTH = 32
);
  logic                     rd_valid;
  logic                     rd_ready;
  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic [8:0]               rd_len;
  logic                     rd_data_valid;
  logic [31:0]              rd_data;

  modport master (
    output rd_valid, rd_addr, rd_len,
    input  rd_ready, rd_data_valid, rd_data
  );

  modport slave (
    input  rd_valid, rd_addr, rd_len,
    output rd_ready, rd_data_valid, rd_data
  );
endinterface

// File: rtl/painterengine_gpu_dvi_scanout.sv
// Framebuffer scanout: burst-reads the front buffer into a FWFT pixel FIFO, one pixel per next_rgb.
// Latency: a pushed word is visible on o_wire_rgba the cycle after its data beat.
// Backpressure: a burst is only requested when the FIFO has room for all of it; pops on empty set underflow.
module painterengine_gpu_dvi_scanout #(
  parameter int FIFO_DEPTH    = 64,
  parameter int BURST_LEN     = 16,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     i_wire_pixel_clock,
  input  logic                     i_wire_reset,
  input  logic                     i_wire_enable,
  input  logic                     i_wire_frame_start,
  input  logic                     i_wire_next_rgb,
  output logic [31:0]              o_wire_rgba,
  input  logic [15:0]              i_wire_clip_width,
  input  logic [15:0]              i_wire_clip_height,
  input  logic [ADDRESS_WIDTH-1:0] i_wire_fb_addr,
  input  logic                     i_wire_swap_req,
  output logic                     o_wire_swap_done,
  painterengine_gpu_dvi_scanout_if.master rd,
  output logic                     o_wire_underflow,
  output logic                     o_wire_busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_REQ, S_DATA, S_DONE} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [31:0]              remaining;
  logic [ADDRESS_WIDTH-1:0] cur_addr;
  logic [ADDRESS_WIDTH-1:0] front_addr;
  logic [ADDRESS_WIDTH-1:0] back_addr;
  logic                     swap_pending;
  logic                     restart_pending;
  logic                     swap_done;
  logic                     underflow;
  logic [8:0]               beats;

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [8:0] len;
  logic       fits;
  logic       beat;
  logic       last_beat;
  logic       discard;
  logic       restart_now;
  logic       restart;
  logic       push;
  logic       pop;
  logic       burst_end;

  // Burst sizing and the per-cycle event decode shared by the FSM and datapath.
  always_comb begin
    len = 9'(BURST_LEN);
    if (remaining < 32'(BURST_LEN)) begin
      len = remaining[8:0];
    end
    fits      = (32'(count) + 32'(len)) <= 32'(FIFO_DEPTH);
    beat      = (state == S_DATA) && rd.rd_data_valid;
    last_beat = beat && (beats == 9'd1);
    // Beats of a burst that straddles a frame start belong to the old frame.
    discard   = restart_pending || i_wire_frame_start;
    restart_now = i_wire_frame_start &&
                  ((state == S_CHECK) || (state == S_DONE) ||
                   ((state == S_IDLE) && i_wire_enable));
    restart   = restart_now || (last_beat && discard);
    push      = beat && !discard;
    pop       = i_wire_next_rgb && (count != '0);
    burst_end = last_beat && !discard;
  end

  // State register.
  always_ff @(posedge i_wire_pixel_clock or posedge i_wire_reset) begin
    if (i_wire_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: restarts win, enable is only honoured between bursts.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (restart) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (restart)                  state_nxt = i_wire_enable ? S_CHECK : S_IDLE;
        else if (!i_wire_enable)      state_nxt = S_IDLE;
        else if (remaining == 32'd0)  state_nxt = S_DONE;
        else if (fits)                state_nxt = S_REQ;
      end
      S_REQ: begin
        if (rd.rd_ready) state_nxt = S_DATA;
      end
      S_DATA: begin
        if (last_beat) state_nxt = i_wire_enable ? S_CHECK : S_IDLE;
      end
      S_DONE: begin
        if (restart)             state_nxt = i_wire_enable ? S_CHECK : S_IDLE;
        else if (!i_wire_enable) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame bookkeeping: addresses, remaining count, buffer swap, burst beat counter, underflow.
  always_ff @(posedge i_wire_pixel_clock or posedge i_wire_reset) begin
    if (i_wire_reset) begin
      remaining       <= '0;
      cur_addr        <= '0;
      front_addr      <= '0;
      back_addr       <= '0;
      swap_pending    <= 1'b0;
      restart_pending <= 1'b0;
      swap_done       <= 1'b0;
      underflow       <= 1'b0;
      beats           <= '0;
    end else begin
      swap_done <= 1'b0;
      if (restart) begin
        remaining       <= {16'd0, i_wire_clip_width} * {16'd0, i_wire_clip_height};
        restart_pending <= 1'b0;
        if (swap_pending) begin
          front_addr   <= back_addr;
          cur_addr     <= back_addr;
          swap_pending <= 1'b0;
          swap_done    <= 1'b1;
        end else begin
          cur_addr <= front_addr;
        end
      end else begin
        if (burst_end) begin
          cur_addr  <= cur_addr + ADDRESS_WIDTH'({len, 2'b00});
          remaining <= remaining - 32'(len);
        end
        if (i_wire_frame_start && ((state == S_REQ) || (state == S_DATA))) begin
          restart_pending <= 1'b1;
        end
      end
      // A request seen on a restart cycle is kept for the frame after.
      if (i_wire_swap_req) begin
        back_addr    <= i_wire_fb_addr;
        swap_pending <= 1'b1;
      end
      if ((state == S_REQ) && rd.rd_ready) begin
        beats <= len;
      end else if (beat) begin
        beats <= beats - 9'd1;
      end
      if (i_wire_next_rgb && (count == '0)) begin
        underflow <= 1'b1;
      end
    end
  end

  // Pixel FIFO pointers and occupancy; a restart flushes it.
  always_ff @(posedge i_wire_pixel_clock or posedge i_wire_reset) begin
    if (i_wire_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (restart) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Pixel storage; contents need no reset because count gates visibility.
  always_ff @(posedge i_wire_pixel_clock) begin
    if (push) fifo_mem[wr_ptr] <= rd.rd_data;
  end

  assign o_wire_rgba      = (count != '0) ? fifo_mem[rd_ptr] : 32'd0;
  assign rd.rd_valid      = (state == S_REQ);
  assign rd.rd_addr       = cur_addr;
  assign rd.rd_len        = len;
  assign o_wire_swap_done = swap_done;
  assign o_wire_underflow = underflow;
  assign o_wire_busy      = (state != S_IDLE);
endmodule
